// File: rtl/wcd_stack_engine_if.sv
// Command/response and stack-bus signal bundle for wcd_stack_engine.
// MAX_BYTES and LEN_W must match the parameters of the engine it is bound to.
interface wcd_stack_engine_if #(
  parameter int MAX_BYTES = 3,
  parameter int LEN_W     = 2
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_op;
  logic [LEN_W-1:0]       cmd_len;
  logic [8*MAX_BYTES-1:0] cmd_wdata;
  logic                   rsp_valid;
  logic [8*MAX_BYTES-1:0] rsp_rdata;
  logic                   rsp_err;
  logic [15:0]            AB;
  logic [7:0]             DB;
  logic                   nRD;
  logic                   nWR;
  logic [7:0]             DB_IN;
  logic [7:0]             Status_SP;
  logic                   sp_wrap;

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_wdata, DB_IN,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, AB, DB, nRD, nWR, Status_SP, sp_wrap
  );

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_wdata, DB_IN,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, AB, DB, nRD, nWR, Status_SP, sp_wrap
  );
endinterface

// File: rtl/wcd_stack_engine.sv
// Stack-transfer engine: multi-byte push/pull against a fixed stack page, owns SP.
// state | meaning
// IDLE  | cmd_ready high, bus idle
// PUSH  | one write per byte; also a one-cycle hold for load SP / rejected commands (len_q = 0)
// PULL  | one read per byte, read data captured one cycle after its address
// DONE  | rsp_valid pulse; a new command may already be accepted here
module wcd_stack_engine #(
  parameter logic [7:0] STACK_PAGE = 8'h01,
  parameter logic [7:0] SP_RESET   = 8'hFD,
  parameter int         MAX_BYTES  = 3,
  parameter int         LEN_W      = 2
) (
  input logic               Clk,
  input logic               Rst,
  wcd_stack_engine_if.slave bus
);
  localparam int DW = 8 * MAX_BYTES;
  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_PULL = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  typedef enum logic [1:0] {IDLE, PUSH, PULL, DONE} state_t;

  state_t           state;
  logic [7:0]       sp;
  logic             sp_wrap_q;
  logic [1:0]       op_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx;
  logic [DW-1:0]    wdata_q;
  logic             err_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [DW-1:0]    rsp_rdata_q;
  logic [15:0]      ab_q;
  logic [7:0]       db_q;
  logic             nrd_q;
  logic             nwr_q;

  logic             accept;
  logic             len_ok;
  logic             cmd_bus;
  logic [DW-1:0]    sel_data;
  logic [LEN_W-1:0] sel_len;
  logic [LEN_W-1:0] sel_idx;
  logic [DW-1:0]    sel_shift;
  logic [7:0]       push_byte;
  int               shift_amt;

  // The first push byte comes straight from the command; later ones from the latched copy.
  always_comb begin
    accept  = bus.cmd_valid && cmd_ready_q;
    len_ok  = (bus.cmd_len != '0) && (int'(bus.cmd_len) <= MAX_BYTES);
    cmd_bus = len_ok && ((bus.cmd_op == OP_PUSH) || (bus.cmd_op == OP_PULL));
    if (state == PUSH) begin
      sel_data = wdata_q;
      sel_len  = len_q;
      sel_idx  = idx;
    end else begin
      sel_data = bus.cmd_wdata;
      sel_len  = bus.cmd_len;
      sel_idx  = '0;
    end
    shift_amt = 8 * (int'(sel_len) - 1 - int'(sel_idx));
    if (shift_amt < 0) shift_amt = 0;
    sel_shift = sel_data >> shift_amt;
    push_byte = sel_shift[7:0];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      sp          <= SP_RESET;
      sp_wrap_q   <= 1'b0;
      op_q        <= '0;
      len_q       <= '0;
      idx         <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      ab_q        <= '0;
      db_q        <= '0;
      nrd_q       <= 1'b1;
      nwr_q       <= 1'b1;
    end else begin
      ab_q        <= '0;
      db_q        <= '0;
      nrd_q       <= 1'b1;
      nwr_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (accept) begin
            op_q        <= bus.cmd_op;
            wdata_q     <= bus.cmd_wdata;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            idx         <= LEN_W'(1);
            err_q       <= 1'b0;
            len_q       <= bus.cmd_len;
            if (cmd_bus && (bus.cmd_op == OP_PUSH)) begin
              ab_q  <= {STACK_PAGE, sp};
              db_q  <= push_byte;
              nwr_q <= 1'b0;
              sp    <= sp - 8'd1;
              if (sp == 8'h00) sp_wrap_q <= 1'b1;
              state <= PUSH;
            end else if (cmd_bus) begin
              ab_q  <= {STACK_PAGE, sp + 8'd1};
              nrd_q <= 1'b0;
              sp    <= sp + 8'd1;
              if (sp == 8'hFF) sp_wrap_q <= 1'b1;
              state <= PULL;
            end else begin
              len_q <= '0;
              idx   <= '0;
              err_q <= (bus.cmd_op != OP_LOAD);
              state <= PUSH;
            end
          end
        end
        PUSH: begin
          if (idx == len_q) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            cmd_ready_q <= 1'b1;
            state       <= DONE;
            if ((op_q == OP_LOAD) && !err_q) begin
              sp        <= wdata_q[7:0];
              sp_wrap_q <= 1'b0;
            end
          end else begin
            ab_q  <= {STACK_PAGE, sp};
            db_q  <= push_byte;
            nwr_q <= 1'b0;
            sp    <= sp - 8'd1;
            if (sp == 8'h00) sp_wrap_q <= 1'b1;
            idx   <= idx + LEN_W'(1);
          end
        end
        PULL: begin
          // DB_IN belongs to the read driven on the previous edge (byte idx-1).
          for (int k = 0; k < MAX_BYTES; k++) begin
            if (int'(idx) == k + 1) rsp_rdata_q[8*k +: 8] <= bus.DB_IN;
          end
          if (idx == len_q) begin
            rsp_valid_q <= 1'b1;
            cmd_ready_q <= 1'b1;
            state       <= DONE;
          end else begin
            ab_q  <= {STACK_PAGE, sp + 8'd1};
            nrd_q <= 1'b0;
            sp    <= sp + 8'd1;
            if (sp == 8'hFF) sp_wrap_q <= 1'b1;
            idx   <= idx + LEN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.AB        = ab_q;
  assign bus.DB        = db_q;
  assign bus.nRD       = nrd_q;
  assign bus.nWR       = nwr_q;
  assign bus.Status_SP = sp;
  assign bus.sp_wrap   = sp_wrap_q;
endmodule

// File: tb/tb_wcd_stack_engine.sv
// Scoreboard bench for wcd_stack_engine: stack-level reference model feeds expectation
// queues; a negedge monitor pops them as the DUT drives bus cycles and responses.
module tb_wcd_stack_engine;
  localparam int MAXB = 3;
  localparam int LW   = 3;
  localparam int DW   = 8 * MAXB;
  localparam logic [7:0] PAGE = 8'h01;
  localparam logic [7:0] SPR  = 8'hFD;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  wcd_stack_engine_if #(.MAX_BYTES(MAXB), .LEN_W(LW)) sif ();

  wcd_stack_engine #(
    .STACK_PAGE(PAGE), .SP_RESET(SPR), .MAX_BYTES(MAXB), .LEN_W(LW)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(sif.slave)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  sp;
  } bus_exp_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic [7:0]    sp;
    logic          wrap;
    int            due;
  } rsp_exp_t;

  bus_exp_t   bus_q[$];
  rsp_exp_t   rsp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] mem[256];
  logic [7:0] ref_mem[256];
  logic [7:0] ref_sp;
  logic       ref_wrap;

  always @(posedge Clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory slave: read data valid during the cycle after the address edge.
  always @(negedge Clk) begin
    if (sif.nWR === 1'b0) mem[sif.AB[7:0]] = sif.DB;
    sif.DB_IN = (sif.nRD === 1'b0) ? mem[sif.AB[7:0]] : 8'($urandom);
  end

  always @(negedge Clk) begin : monitor
    bus_exp_t be;
    rsp_exp_t re;
    if ((sif.nWR === 1'b0) || (sif.nRD === 1'b0)) begin
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bus_cycle: AB=%h nRD=%b nWR=%b, expected no strobe", sif.AB, sif.nRD, sif.nWR);
      end else begin
        be = bus_q.pop_front();
        chk("bus_kind_wr", 32'(sif.nWR === 1'b0), 32'(be.wr));
        chk("bus_kind_rd", 32'(sif.nRD === 1'b0), 32'(!be.wr));
        chk("bus_addr", 32'(sif.AB), 32'(be.addr));
        if (be.wr) chk("bus_wdata", 32'(sif.DB), 32'(be.data));
        chk("bus_status_sp", 32'(sif.Status_SP), 32'(be.sp));
      end
    end
    if (sif.rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h, expected no response", sif.rsp_rdata);
      end else begin
        re = rsp_q.pop_front();
        chk("rsp_latency", 32'(cyc), 32'(re.due));
        chk("rsp_rdata", 32'(sif.rsp_rdata), 32'(re.rdata));
        chk("rsp_err", 32'(sif.rsp_err), 32'(re.err));
        chk("rsp_sp", 32'(sif.Status_SP), 32'(re.sp));
        chk("rsp_wrap", 32'(sif.sp_wrap), 32'(re.wrap));
      end
    end
  end

  // Stack-level model: push stores bytes MSB first downward, pull returns them LSB first.
  task automatic model(input logic [1:0] op, input logic [LW-1:0] len, input logic [DW-1:0] wd, input int acc);
    rsp_exp_t r;
    bus_exp_t b;
    int n;
    n = int'(len);
    r.rdata = '0;
    r.err   = 1'b0;
    r.due   = acc + 1;
    if ((op == 2'b11) || ((op != 2'b10) && ((n < 1) || (n > MAXB)))) begin
      r.err = 1'b1;
    end else if (op == 2'b10) begin
      ref_sp   = wd[7:0];
      ref_wrap = 1'b0;
    end else if (op == 2'b00) begin
      for (int k = n - 1; k >= 0; k--) begin
        b.wr   = 1'b1;
        b.addr = {PAGE, ref_sp};
        b.data = 8'(wd >> (8 * k));
        ref_mem[ref_sp] = b.data;
        if (ref_sp == 8'h00) ref_wrap = 1'b1;
        ref_sp = ref_sp - 8'd1;
        b.sp = ref_sp;
        bus_q.push_back(b);
      end
      r.due = acc + n;
    end else begin
      for (int j = 0; j < n; j++) begin
        if (ref_sp == 8'hFF) ref_wrap = 1'b1;
        ref_sp = ref_sp + 8'd1;
        b.wr   = 1'b0;
        b.addr = {PAGE, ref_sp};
        b.data = 8'h00;
        b.sp   = ref_sp;
        bus_q.push_back(b);
        r.rdata = r.rdata | (DW'(ref_mem[ref_sp]) << (8 * j));
      end
      r.due = acc + n;
    end
    r.sp   = ref_sp;
    r.wrap = ref_wrap;
    rsp_q.push_back(r);
  endtask

  task automatic issue(input logic [1:0] op, input logic [LW-1:0] len, input logic [DW-1:0] wd,
                       input bit hold, output int acc);
    @(negedge Clk);
    sif.cmd_valid = 1'b1;
    sif.cmd_op    = op;
    sif.cmd_len   = len;
    sif.cmd_wdata = wd;
    for (int t = 0; t < 50 && (sif.cmd_ready !== 1'b1); t++) @(negedge Clk);
    if (sif.cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: cmd_ready=%b, required 1 within 50 cycles", sif.cmd_ready);
      sif.cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    model(op, len, wd, acc);
    @(posedge Clk);
    #1;
    sif.cmd_wdata = DW'($urandom);
    if (!hold) sif.cmd_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int a1, a2;
    logic [1:0]    rop;
    logic [LW-1:0] rlen;
    sif.cmd_valid = 1'b0;
    sif.cmd_op    = 2'b00;
    sif.cmd_len   = '0;
    sif.cmd_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    ref_sp   = SPR;
    ref_wrap = 1'b0;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_AB", 32'(sif.AB), 32'h0);
    chk("rst_DB", 32'(sif.DB), 32'h0);
    chk("rst_nRD", 32'(sif.nRD), 32'h1);
    chk("rst_nWR", 32'(sif.nWR), 32'h1);
    chk("rst_sp", 32'(sif.Status_SP), 32'hFD);
    chk("rst_ready", 32'(sif.cmd_ready), 32'h1);
    chk("rst_rsp_valid", 32'(sif.rsp_valid), 32'h0);
    chk("rst_rdata", 32'(sif.rsp_rdata), 32'h0);
    chk("rst_err", 32'(sif.rsp_err), 32'h0);
    chk("rst_wrap", 32'(sif.sp_wrap), 32'h0);
    Rst = 1'b0;

    issue(2'b00, 3'd1, 24'h0000AA, 1'b0, a1);
    issue(2'b10, 3'd0, 24'h0000FD, 1'b0, a1);
    issue(2'b00, 3'd2, 24'h001234, 1'b0, a1);
    issue(2'b01, 3'd2, 24'h000000, 1'b0, a1);
    issue(2'b10, 3'd0, 24'h000000, 1'b0, a1);
    issue(2'b00, 3'd2, 24'h00BEEF, 1'b0, a1);
    issue(2'b10, 3'd0, 24'h0000FD, 1'b0, a1);
    issue(2'b00, 3'd0, 24'h123456, 1'b0, a1);
    issue(2'b00, 3'd4, 24'h123456, 1'b0, a1);
    issue(2'b11, 3'd1, 24'h123456, 1'b0, a1);
    issue(2'b01, 3'd7, 24'h000000, 1'b0, a1);
    issue(2'b01, 3'd3, 24'h000000, 1'b1, a1);
    issue(2'b00, 3'd1, 24'h000055, 1'b0, a2);
    chk("b2b_accept_gap", 32'(a2 - a1), 32'd4);
    issue(2'b10, 3'd0, 24'h0000FD, 1'b0, a1);
    repeat (3) @(negedge Clk);

    // Abort a len3 push right after its first write.
    @(negedge Clk);
    sif.cmd_valid = 1'b1;
    sif.cmd_op    = 2'b00;
    sif.cmd_len   = 3'd3;
    sif.cmd_wdata = 24'hC3D4E5;
    chk("abort_ready", 32'(sif.cmd_ready), 32'h1);
    bus_q.push_back('{wr: 1'b1, addr: {PAGE, ref_sp}, data: 8'hC3, sp: ref_sp - 8'd1});
    ref_mem[ref_sp] = 8'hC3;
    @(posedge Clk);
    #2;
    sif.cmd_valid = 1'b0;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    ref_sp   = SPR;
    ref_wrap = 1'b0;
    @(negedge Clk);
    chk("abort_sp", 32'(sif.Status_SP), 32'hFD);
    chk("abort_ready_after", 32'(sif.cmd_ready), 32'h1);
    chk("abort_rsp_valid", 32'(sif.rsp_valid), 32'h0);
    chk("abort_nWR", 32'(sif.nWR), 32'h1);
    repeat (6) @(negedge Clk);

    for (int it = 0; it < 300; it++) begin
      int sel;
      sel = int'($urandom_range(0, 19));
      if (sel < 8)       rop = 2'b00;
      else if (sel < 16) rop = 2'b01;
      else if (sel < 18) rop = 2'b10;
      else               rop = 2'b11;
      if ($urandom_range(0, 99) < 10) rlen = LW'($urandom_range(0, 7));
      else                            rlen = LW'($urandom_range(1, MAXB));
      issue(rop, rlen, DW'($urandom), ($urandom_range(0, 1) == 1), a1);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge Clk);
        sif.cmd_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge Clk);
      end
    end
    @(negedge Clk);
    sif.cmd_valid = 1'b0;

    for (int t = 0; t < 50 && (bus_q.size() + rsp_q.size()) != 0; t++) @(negedge Clk);
    repeat (3) @(negedge Clk);
    chk("queues_drained", 32'(bus_q.size() + rsp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wcd_stack_engine.md
# wcd_stack_engine

Parametrised stack-transfer engine for the WCD65C02 core. It executes multi-byte push and pull commands against a fixed stack page and issues the bus cycles itself. Commands are single bytes (PHA/PLA) or multi-byte frames (JSR/RTS return address, interrupt frames). It sits between the core's sequencer (command/response side) and the shared address/data bus, and owns the Stack Pointer.

## Interface

Parameters:
- `STACK_PAGE`, default 8'h01: high address byte of every stack access.
- `SP_RESET`, default 8'hFD: SP value after reset.
- `MAX_BYTES`, default 3: maximum bytes per command; legal range 1..4.
- `LEN_W`, default 2: width of `cmd_len`; must hold `MAX_BYTES`.

Ports (name, direction, width, meaning):
- `Clk` in 1: single clock, rising edge.
- `Rst` in 1: reset, synchronous and active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: engine idle; command accepted on an edge where both `cmd_valid` and `cmd_ready` are high.
- `cmd_op` in 2: operation code.
  - 00 push.
  - 01 pull.
  - 10 load SP.
  - 11 reserved.
- `cmd_len` in LEN_W: byte count.
- `cmd_wdata` in 8*MAX_BYTES: push data; for load SP, `[7:0]` is the new SP.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 8*MAX_BYTES: pulled data, valid while `rsp_valid` is high.
- `rsp_err` out 1: illegal length, qualified by `rsp_valid`.
- `AB` out 16: address bus.
- `DB` out 8: write data.
- `nRD` out 1: read strobe, active low.
- `nWR` out 1: write strobe, active low.
- `DB_IN` in 8: read data; memory returns it one cycle after the read address is driven.
- `Status_SP` out 8: current SP.
- `sp_wrap` out 1: sticky stack wrap flag.

## Operation

States:
- IDLE: `cmd_ready`=1, bus idle (`AB`=0, `DB`=0, `nRD`=`nWR`=1).
- PUSH, PULL: one bus cycle per byte.
- DONE: drives `rsp_valid`, then returns to IDLE.

Push of N bytes:
- Bus cycle i (i=0..N-1) writes `cmd_wdata[8*(N-1-i)+:8]` to {STACK_PAGE, SP} with `nWR`=0.
- SP decrements after each byte. The most significant byte goes to the highest address.

Pull of N bytes:
- Before each byte, SP increments, then a read is issued at {STACK_PAGE, new SP}.
- The byte from read cycle j lands in `rsp_rdata[8*j+:8]`, so the first byte pulled is least significant.
- Bytes above N in `rsp_rdata` are 0.

Load SP:
- SP is set to `cmd_wdata[7:0]`.
- `sp_wrap` clears.
- No bus cycle.

Reserved op (11): no bus cycle, SP unchanged, `rsp_err`=1.

Illegal length (`cmd_len`=0 or `cmd_len`>MAX_BYTES) on push or pull: no bus cycle, SP unchanged, `rsp_err`=1.

Arithmetic: SP is 8-bit modulo.
- A push at SP=00 writes to {page,00}, then SP becomes FF.
- A pull at SP=FF increments SP to 00, then reads from {page,00}.
- Either case sets `sp_wrap`; it stays set until load SP or `Rst`.

Command data is latched on acceptance; input changes after acceptance have no effect.

## Timing

All outputs are registered.

Reset values:
- `AB`=0, `DB`=0, `nRD`=1, `nWR`=1.
- SP=SP_RESET, `cmd_ready`=1.
- `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `sp_wrap`=0.

Push/pull timeline, with the command accepted at edge E0:
- Bus cycle i is driven from edge E0+i (i=0..N-1). `nRD`/`nWR` stay low for exactly those N cycles.
- On a pull, `DB_IN` for the cycle driven at E0+i is sampled at E0+i+1.
- `cmd_ready` is low after E0.
- At edge E0+N: bus goes idle, `rsp_valid`=1, and `rsp_rdata` is complete.
- At edge E0+N+1: `rsp_valid`=0, `cmd_ready`=1.
- Earliest next acceptance is E0+N+1. Throughput is one command per N+1 cycles.

Load SP, reserved op and illegal length:
- `rsp_valid` at E0+1; `cmd_ready` back at E0+2.
- For load SP, `Status_SP` shows the new value from E0+1.

`Status_SP` updates on the same edge as each corresponding bus cycle.

`Rst` has priority over everything. Asserting it mid-command aborts the transfer: at the next edge all outputs return to reset values, no further strobes are issued, and no `rsp_valid` is produced.

## Test plan

- Reset, then push len1 with `cmd_wdata`=AA:
  - Write AA to 01FD on the cycle after acceptance.
  - SP=FC.
  - `rsp_valid` at E0+1.
- Push len2 0x1234 from SP=FD, then pull len2:
  - Writes 12@01FD, 34@01FC; SP=FB.
  - Reads 01FC, 01FD.
  - `rsp_rdata`=0x001234; SP=FD.
- Load SP 00, then push len2 0xBEEF:
  - Writes BE@0100, EF@01FF; SP=FE.
  - `sp_wrap`=1.
  - A second load SP clears `sp_wrap`.
- Push with `cmd_len`=0 and with `cmd_len`=MAX_BYTES+1, and a command with `cmd_op`=11:
  - No strobes, SP unchanged.
  - `rsp_valid` and `rsp_err` high at E0+1.
- Pull len3 with `cmd_valid` held high continuously:
  - Exactly 3 read strobes.
  - `rsp_valid` is a 1-cycle pulse at E0+3.
  - Next command accepted at E0+4.
- Assert `Rst` for one cycle after the first write of a len3 push:
  - No further `nWR`.
  - SP=FD, `cmd_ready`=1, `rsp_valid` never asserted.
